// File: rtl/wb_stage_ext.sv
// Writeback stage: MEM/WB pipeline register, load alignment/extension,
// misaligned-load detection and four-way writeback select.
module wb_stage_ext #(
   parameter int DATA_W           = 32,
   parameter int REG_ADDR_W       = 5,
   parameter int ZERO_REG_PROTECT = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  stall_i,
   input  logic                  flush_i,
   input  logic                  valid_i,
   input  logic                  reg_write_i,
   input  logic [1:0]            wb_sel_i,
   input  logic [2:0]            load_type_i,
   input  logic [REG_ADDR_W-1:0] dest_i,
   input  logic [DATA_W-1:0]     alu_i,
   input  logic [DATA_W-1:0]     mem_i,
   input  logic [DATA_W-1:0]     link_i,
   input  logic [DATA_W-1:0]     imm_i,
   output logic                  reg_we_o,
   output logic [REG_ADDR_W-1:0] reg_waddr_o,
   output logic [DATA_W-1:0]     reg_wdata_o,
   output logic                  misalign_o,
   output logic                  valid_o
);

   localparam int OFF_W = (DATA_W == 64) ? 3 : 2;

   typedef enum logic [1:0] {
      SEL_ALU  = 2'd0,
      SEL_MEM  = 2'd1,
      SEL_LINK = 2'd2,
      SEL_IMM  = 2'd3
   } wb_sel_t;

   typedef enum logic [2:0] {
      LD_B  = 3'b000,
      LD_H  = 3'b001,
      LD_W  = 3'b010,
      LD_BU = 3'b100,
      LD_HU = 3'b101
   } ld_t;

   logic                  valid_q;
   logic                  reg_write_q;
   logic [1:0]            wb_sel_q;
   logic [2:0]            load_type_q;
   logic [REG_ADDR_W-1:0] dest_q;
   logic [DATA_W-1:0]     alu_q;
   logic [DATA_W-1:0]     mem_q;
   logic [DATA_W-1:0]     link_q;
   logic [DATA_W-1:0]     imm_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         wb_sel_q    <= '0;
         load_type_q <= '0;
         dest_q      <= '0;
         alu_q       <= '0;
         mem_q       <= '0;
         link_q      <= '0;
         imm_q       <= '0;
      end else if (flush_i) begin
         valid_q     <= 1'b0;
      end else if (!stall_i) begin
         valid_q     <= valid_i;
         reg_write_q <= reg_write_i;
         wb_sel_q    <= wb_sel_i;
         load_type_q <= load_type_i;
         dest_q      <= dest_i;
         alu_q       <= alu_i;
         mem_q       <= mem_i;
         link_q      <= link_i;
         imm_q       <= imm_i;
      end
   end

   logic [OFF_W-1:0]  off;
   logic [7:0]        byte_v;
   logic [15:0]       half_v;
   logic [31:0]       word_v;
   logic [DATA_W-1:0] load_data;
   logic              is_half;
   logic              is_word;
   logic              misaligned;
   logic              zero_block;

   assign off = alu_q[OFF_W-1:0];

   // Lanes are taken by shifting the whole word down, so offsets that run
   // past the top (only possible on misaligned loads) read zeros, never X.
   always_comb begin
      byte_v = 8'(mem_q >> {off, 3'b000});
      half_v = 16'(mem_q >> {off, 3'b000});
      if (DATA_W == 64) word_v = 32'(mem_q >> {off[OFF_W-1], 5'b00000});
      else              word_v = 32'(mem_q);
      is_half   = 1'b0;
      is_word   = 1'b0;
      load_data = '0;
      case (load_type_q)
         LD_B:  load_data = DATA_W'($signed(byte_v));
         LD_BU: load_data = DATA_W'(byte_v);
         LD_H: begin
            is_half   = 1'b1;
            load_data = DATA_W'($signed(half_v));
         end
         LD_HU: begin
            is_half   = 1'b1;
            load_data = DATA_W'(half_v);
         end
         default: begin
            is_word   = 1'b1;
            load_data = DATA_W'($signed(word_v));
         end
      endcase
   end

   always_comb begin
      misaligned  = (is_half & off[0]) | (is_word & (off[1:0] != 2'b00));
      misalign_o  = valid_q & reg_write_q & (wb_sel_q == SEL_MEM) & misaligned;
      zero_block  = (ZERO_REG_PROTECT != 0) && (dest_q == '0);
      reg_we_o    = valid_q & reg_write_q & ~misalign_o & ~zero_block;
      reg_waddr_o = dest_q;
      valid_o     = valid_q;
      case (wb_sel_q)
         SEL_ALU:  reg_wdata_o = alu_q;
         SEL_MEM:  reg_wdata_o = load_data;
         SEL_LINK: reg_wdata_o = link_q;
         default:  reg_wdata_o = imm_q;
      endcase
   end

endmodule

// File: tb/tb_wb_stage_ext.sv
// Bench for wb_stage_ext: directed steps then random traffic, three instances
// (32-bit protected, 32-bit unprotected, 64-bit) against a behavioural model.
module tb_wb_stage_ext;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, stall_i, flush_i, valid_i, reg_write_i;
   logic [1:0]  wb_sel_i;
   logic [2:0]  load_type_i;
   logic [4:0]  dest_i;
   logic [63:0] alu_i, mem_i, link_i, imm_i;

   logic        a_we, a_mis, a_vo;
   logic [4:0]  a_wa;
   logic [31:0] a_wd;
   logic        b_we, b_mis, b_vo;
   logic [4:0]  b_wa;
   logic [31:0] b_wd;
   logic        c_we, c_mis, c_vo;
   logic [4:0]  c_wa;
   logic [63:0] c_wd;

   int checks = 0;
   int errors = 0;

   wb_stage_ext #(.DATA_W(32), .REG_ADDR_W(5), .ZERO_REG_PROTECT(1)) dut (
      .clk(clk), .reset_n(reset_n), .stall_i(stall_i), .flush_i(flush_i),
      .valid_i(valid_i), .reg_write_i(reg_write_i), .wb_sel_i(wb_sel_i),
      .load_type_i(load_type_i), .dest_i(dest_i), .alu_i(alu_i[31:0]),
      .mem_i(mem_i[31:0]), .link_i(link_i[31:0]), .imm_i(imm_i[31:0]),
      .reg_we_o(a_we), .reg_waddr_o(a_wa), .reg_wdata_o(a_wd),
      .misalign_o(a_mis), .valid_o(a_vo));

   wb_stage_ext #(.DATA_W(32), .REG_ADDR_W(5), .ZERO_REG_PROTECT(0)) dut_np (
      .clk(clk), .reset_n(reset_n), .stall_i(stall_i), .flush_i(flush_i),
      .valid_i(valid_i), .reg_write_i(reg_write_i), .wb_sel_i(wb_sel_i),
      .load_type_i(load_type_i), .dest_i(dest_i), .alu_i(alu_i[31:0]),
      .mem_i(mem_i[31:0]), .link_i(link_i[31:0]), .imm_i(imm_i[31:0]),
      .reg_we_o(b_we), .reg_waddr_o(b_wa), .reg_wdata_o(b_wd),
      .misalign_o(b_mis), .valid_o(b_vo));

   wb_stage_ext #(.DATA_W(64), .REG_ADDR_W(5), .ZERO_REG_PROTECT(1)) dut64 (
      .clk(clk), .reset_n(reset_n), .stall_i(stall_i), .flush_i(flush_i),
      .valid_i(valid_i), .reg_write_i(reg_write_i), .wb_sel_i(wb_sel_i),
      .load_type_i(load_type_i), .dest_i(dest_i), .alu_i(alu_i),
      .mem_i(mem_i), .link_i(link_i), .imm_i(imm_i),
      .reg_we_o(c_we), .reg_waddr_o(c_wa), .reg_wdata_o(c_wd),
      .misalign_o(c_mis), .valid_o(c_vo));

   // Model of the instruction currently held in writeback
   logic        m_valid, m_rw;
   logic [1:0]  m_sel;
   logic [2:0]  m_lt;
   logic [4:0]  m_dest;
   logic [63:0] m_alu, m_mem, m_link, m_imm;
   bit          m_dc;   // fields other than valid are unspecified after a flush

   function automatic logic [63:0] r64();
      return {$urandom, $urandom};
   endfunction

   function automatic int ld_size(input logic [2:0] lt);
      if (lt == 3'b000 || lt == 3'b100) return 1;
      if (lt == 3'b001 || lt == 3'b101) return 2;
      return 4;
   endfunction

   function automatic int ld_off(input int w);
      return int'(m_alu % 64'(w / 8));
   endfunction

   function automatic bit misal(input int w);
      int off, size;
      off  = ld_off(w);
      size = ld_size(m_lt);
      return (size == 2 && off % 2 != 0) || (size == 4 && off % 4 != 0);
   endfunction

   function automatic logic [63:0] exp_load(input int w);
      int off, size, start;
      bit sgn;
      logic [63:0] wmask, mask, v;
      wmask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      off   = ld_off(w);
      size  = ld_size(m_lt);
      sgn   = !(m_lt == 3'b100 || m_lt == 3'b101);
      start = (size == 4) ? (off / 4) * 4 : off;
      mask  = (64'd1 << (8 * size)) - 64'd1;
      v     = ((m_mem & wmask) >> (8 * start)) & mask;
      if (sgn && v[8 * size - 1]) v = v | ~mask;
      return v & wmask;
   endfunction

   task automatic cmp(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_inst(input string tag, input int w, input bit zrp,
                             input logic [63:0] we, input logic [63:0] wa,
                             input logic [63:0] wd, input logic [63:0] mis,
                             input logic [63:0] vo);
      logic        e_mis, e_we;
      logic [63:0] e_wd, wmask;
      wmask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      e_mis = m_valid && m_rw && (m_sel == 2'd1) && misal(w);
      e_we  = m_valid && m_rw && !e_mis && !(zrp && m_dest == 5'd0);
      case (m_sel)
         2'd0:    e_wd = m_alu & wmask;
         2'd1:    e_wd = exp_load(w);
         2'd2:    e_wd = m_link & wmask;
         default: e_wd = m_imm & wmask;
      endcase
      cmp({tag, " valid_o"}, vo, 64'(m_valid));
      cmp({tag, " misalign_o"}, mis, 64'(e_mis));
      cmp({tag, " reg_we_o"}, we, 64'(e_we));
      if (!m_dc) begin
         cmp({tag, " reg_waddr_o"}, wa, 64'(m_dest));
         if (!e_mis) cmp({tag, " reg_wdata_o"}, wd, e_wd);
      end
   endtask

   task automatic check_all(input string tag);
      check_inst({tag, "/p32"}, 32, 1'b1, 64'(a_we), 64'(a_wa), 64'(a_wd), 64'(a_mis), 64'(a_vo));
      check_inst({tag, "/np32"}, 32, 1'b0, 64'(b_we), 64'(b_wa), 64'(b_wd), 64'(b_mis), 64'(b_vo));
      check_inst({tag, "/p64"}, 64, 1'b1, 64'(c_we), 64'(c_wa), c_wd, 64'(c_mis), 64'(c_vo));
   endtask

   // One rising edge: update the model from the inputs the DUT samples there.
   task automatic step();
      @(posedge clk);
      if (!reset_n) begin
         m_valid = 1'b0; m_rw = 1'b0; m_sel = '0; m_lt = '0; m_dest = '0;
         m_alu = '0; m_mem = '0; m_link = '0; m_imm = '0; m_dc = 1'b0;
      end else if (flush_i) begin
         m_valid = 1'b0;
         m_dc    = 1'b1;
      end else if (!stall_i) begin
         m_valid = valid_i; m_rw = reg_write_i; m_sel = wb_sel_i; m_lt = load_type_i;
         m_dest = dest_i; m_alu = alu_i; m_mem = mem_i; m_link = link_i; m_imm = imm_i;
         m_dc = 1'b0;
      end
      #1;
   endtask

   initial begin
      m_valid = 1'b0; m_rw = 1'b0; m_sel = '0; m_lt = '0; m_dest = '0;
      m_alu = '0; m_mem = '0; m_link = '0; m_imm = '0; m_dc = 1'b1;

      // Reset held with stall and valid asserted
      reset_n = 1'b0; stall_i = 1'b1; flush_i = 1'b0; valid_i = 1'b1; reg_write_i = 1'b1;
      wb_sel_i = 2'd1; load_type_i = 3'b000; dest_i = 5'd7;
      alu_i = r64(); mem_i = r64(); link_i = r64(); imm_i = r64();
      step();
      check_all("reset1");
      cmp("reset1 wdata", 64'(a_wd), 64'h0);
      step();
      check_all("reset2");

      // LB / LBU
      reset_n = 1'b1; stall_i = 1'b0;
      mem_i = {$urandom, 32'h1234_80FF}; alu_i = {$urandom, 32'h0000_1001};
      dest_i = 5'd5; wb_sel_i = 2'd1; load_type_i = 3'b000;
      step();
      check_all("lb");
      cmp("lb wdata", 64'(a_wd), 64'hFFFF_FF80);
      cmp("lb we", 64'(a_we), 64'd1);
      cmp("lb waddr", 64'(a_wa), 64'd5);
      load_type_i = 3'b100;
      step();
      check_all("lbu");
      cmp("lbu wdata", 64'(a_wd), 64'h0000_0080);

      // Halfword loads, aligned and misaligned
      mem_i = {$urandom, 32'h8001_0000}; alu_i = {$urandom, 32'h0000_1002}; load_type_i = 3'b001;
      step();
      check_all("lh");
      cmp("lh wdata", 64'(a_wd), 64'hFFFF_8001);
      alu_i = {$urandom, 32'h0000_1003};
      step();
      check_all("lh_mis");
      cmp("lh_mis misalign", 64'(a_mis), 64'd1);
      cmp("lh_mis we", 64'(a_we), 64'd0);

      // Misaligned LH without valid never flags
      valid_i = 1'b0;
      step();
      check_all("lh_mis_invalid");
      cmp("lh_mis_invalid misalign", 64'(a_mis), 64'd0);
      valid_i = 1'b1;

      // Source select
      alu_i = 64'hA; link_i = 64'h104; imm_i = 64'h1234_5000;
      wb_sel_i = 2'd0;
      step();
      check_all("sel_alu");
      cmp("sel_alu wdata", 64'(a_wd), 64'hA);
      wb_sel_i = 2'd2;
      step();
      check_all("sel_link");
      cmp("sel_link wdata", 64'(a_wd), 64'h104);
      wb_sel_i = 2'd3;
      step();
      check_all("sel_imm");
      cmp("sel_imm wdata", 64'(a_wd), 64'h1234_5000);

      // Zero register protection
      dest_i = 5'd0; wb_sel_i = 2'd0;
      step();
      check_all("zero");
      cmp("zero protected we", 64'(a_we), 64'd0);
      cmp("zero unprotected we", 64'(b_we), 64'd1);

      // Stall holds, flush wins over stall
      alu_i = 64'h11; dest_i = 5'd3;
      step();
      check_all("cap");
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         alu_i = r64(); dest_i = 5'($urandom); wb_sel_i = 2'($urandom); mem_i = r64();
         step();
         check_all("stall");
         cmp("stall wdata", 64'(a_wd), 64'h11);
         cmp("stall waddr", 64'(a_wa), 64'd3);
      end
      flush_i = 1'b1;
      step();
      check_all("flush");
      cmp("flush valid", 64'(a_vo), 64'd0);
      cmp("flush we", 64'(a_we), 64'd0);

      // Mid-stream reset beats stall and flush
      flush_i = 1'b0; stall_i = 1'b0; alu_i = 64'h55; dest_i = 5'd9; wb_sel_i = 2'd0;
      step();
      check_all("pre_rst");
      reset_n = 1'b0; stall_i = 1'b1; flush_i = 1'b1;
      step();
      check_all("mid_rst");
      cmp("mid_rst waddr", 64'(a_wa), 64'd0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         reset_n     = ($urandom_range(0, 31) != 0);
         stall_i     = ($urandom_range(0, 5) == 0);
         flush_i     = ($urandom_range(0, 9) == 0);
         valid_i     = 1'($urandom);
         reg_write_i = ($urandom_range(0, 3) != 0);
         wb_sel_i    = 2'($urandom);
         load_type_i = 3'($urandom);
         dest_i      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         alu_i = r64(); mem_i = r64(); link_i = r64(); imm_i = r64();
         step();
         check_all("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
